pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, payload width (instr, pc, pc+4 packed).
REQ-002 SHALL have parameter RESET_VAL, default all-zero, DATA_W-bit value loaded into data registers on reset and on flush.
REQ-003 SHALL have parameter FLUSH_CLEAR, default 1; 1 = data registers load RESET_VAL on flush, 0 = data registers hold on flush.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 i_clk  input  1  clock, rising edge.
REQ-006 i_rst  input  1  asynchronous active-high reset.
REQ-007 i_flush  input  1  synchronous flush; discards all held entries.
REQ-008 i_valid  input  1  upstream payload valid.
REQ-009 o_ready  output  1  block can accept; registered output.
REQ-010 i_data  input  DATA_W  upstream payload.
REQ-011 o_valid  output  1  downstream payload valid.
REQ-012 i_ready  input  1  downstream accepts (0 = stall).
REQ-013 o_data  output  DATA_W  downstream payload.
REQ-014 o_count  output  2  entries held (0..2).
REQ-015 o_drop_cnt  output  16  saturating count of valid entries discarded by flush.

Function
REQ-016 SHALL hold a main register (drives o_data) and a skid register, with states EMPTY (0 entries), ONE (main valid), FULL (main+skid valid).
REQ-017 SHALL define input transfer as i_valid & o_ready and output transfer as o_valid & i_ready, both sampled on the rising edge.
REQ-018 o_valid SHALL be 1 in ONE and FULL, 0 in EMPTY; o_ready SHALL be 0 only in FULL; o_count SHALL equal the state's entry count.
REQ-019 EMPTY: input transfer -> ONE, main <= i_data; otherwise stay.
REQ-020 ONE: input and output transfer -> ONE, main <= i_data; input only -> FULL, skid <= i_data; output only -> EMPTY; neither -> hold.
REQ-021 FULL: output transfer -> ONE, main <= skid; no input accepted; otherwise hold.
REQ-022 Latency SHALL be one cycle: data accepted at edge N appears on o_data after edge N when main is free; full throughput of 1 transfer/cycle with i_ready held 1.
REQ-023 Order SHALL be preserved; no payload is duplicated or lost except by flush.
REQ-024 Flush SHALL take priority over all transfers: next state EMPTY; any input offered in the flush cycle is discarded and not counted.
REQ-025 An output transfer in the flush cycle SHALL count as delivered; o_drop_cnt SHALL add entries held minus that delivered entry (0, 1 or 2).
REQ-026 With FLUSH_CLEAR=1, flush SHALL load RESET_VAL into main and skid; with FLUSH_CLEAR=0, data registers SHALL hold.
REQ-027 o_drop_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-028 When EMPTY, o_data SHALL show main register contents (RESET_VAL after reset/flush with FLUSH_CLEAR=1).
REQ-029 o_data SHALL not change while o_valid=1 and i_ready=0.

Reset
REQ-030 On i_rst=1, immediately and independent of i_clk: state EMPTY, o_valid=0, o_ready=1, o_count=0, o_drop_cnt=0, main=skid=RESET_VAL.
REQ-031 Reset mid-operation SHALL discard all entries without incrementing o_drop_cnt.
REQ-032 First transfer SHALL be possible on the first rising edge after i_rst deasserts.

Verification
REQ-033 Streaming: i_ready=1, i_valid=1, i_data=1,2,3,4 on consecutive edges -> o_data=1,2,3,4 one cycle later, o_count=1, o_ready=1 throughout.
REQ-034 Stall/skid: feed A,B with i_ready=0 -> o_count=2, o_ready=0, o_data=A; raise i_ready -> A then B delivered, o_count 2->1->0.
REQ-035 Flush FULL: hold A,B, i_ready=0, pulse i_flush with i_valid=1, i_data=C -> next cycle o_valid=0, o_count=0, o_data=0, o_drop_cnt=2, C never appears.
REQ-036 Flush with delivery: ONE holding A, i_ready=1, i_flush=1 -> A counted delivered, o_drop_cnt unchanged, state EMPTY.
REQ-037 Saturation: preload o_drop_cnt to 16'hFFFE via repeated FULL flushes -> next FULL flush gives 16'hFFFF, further flushes hold 16'hFFFF.
REQ-038 Async reset: assert i_rst between edges while FULL -> outputs at reset values before next edge; o_drop_cnt=0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: main drives o_data, skid absorbs the word in flight when downstream stalls.
// One-cycle latency, one transfer per cycle; o_ready is registered and drops only when both entries are held.
module pipe_skid_reg #(
  parameter int                 DATA_W      = 96,
  parameter logic [DATA_W-1:0]  RESET_VAL   = '0,
  parameter bit                 FLUSH_CLEAR = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count,
  output logic [15:0]       o_drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [15:0]       drop_q, drop_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [1:0]        count_q, count_d;

  logic              in_xfer;
  logic              out_xfer;
  logic [1:0]        drop_inc;
  logic [16:0]       drop_sum;

  assign in_xfer  = i_valid & ready_q;
  assign out_xfer = valid_q & i_ready;

  // A word leaving in the flush cycle was delivered, so only the remainder counts as dropped.
  assign drop_inc = count_q - 2'(out_xfer);
  assign drop_sum = {1'b0, drop_q} + 17'(drop_inc);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    drop_d  = drop_q;

    if (i_flush) begin
      state_d = EMPTY;
      drop_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (FLUSH_CLEAR) begin
        main_d = RESET_VAL;
        skid_d = RESET_VAL;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = i_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = i_data;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_d  = i_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Status outputs are decoded from the next state so they leave the block straight from flops.
  always_comb begin
    ready_d = 1'b1;
    valid_d = 1'b0;
    count_d = 2'd0;
    case (state_d)
      ONE: begin
        valid_d = 1'b1;
        count_d = 2'd1;
      end
      FULL: begin
        valid_d = 1'b1;
        ready_d = 1'b0;
        count_d = 2'd2;
      end
      default: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        count_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      drop_q  <= 16'h0000;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      drop_q  <= drop_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_count    = count_q;
  assign o_data     = main_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: vector table with a payload scoreboard, plus saturation and async-reset sequences.
module tb_pipe_skid_reg;

  localparam int DW = 96;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [1:0]    o_count;
  logic [15:0]   o_drop_cnt;

  int total = 0;
  int bad   = 0;
  int m_drop = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic        f;
    logic        v;
    logic [31:0] d;
    logic        r;
    logic [1:0]  cnt;
    logic [31:0] dat;
    logic [15:0] drop;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl[NV];

  pipe_skid_reg #(.DATA_W(DW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_count    (o_count),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, ".count"}, DW'(o_count), DW'(sz));
    chk({tag, ".valid"}, DW'(o_valid), DW'(sz != 0));
    chk({tag, ".ready"}, DW'(o_ready), DW'(sz < 2));
    chk({tag, ".drop"},  DW'(o_drop_cnt), DW'(m_drop));
  endtask

  // Drives one cycle; the scoreboard pops on output transfers and pushes accepted inputs.
  task automatic step(input logic f, input logic v, input logic [31:0] d, input logic r);
    logic in_x, out_x;
    int held;
    @(negedge i_clk);
    i_flush = f;
    i_valid = v;
    i_data  = {3{d}};
    i_ready = r;
    #1;
    in_x  = v & o_ready;
    out_x = o_valid & r;
    if (out_x) begin
      chk("sb.nonempty", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) begin
        chk("sb.order", o_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    held = exp_q.size();
    @(posedge i_clk);
    #1;
    if (f) begin
      m_drop = (m_drop + held > 65535) ? 65535 : m_drop + held;
      exp_q.delete();
    end else if (in_x) begin
      exp_q.push_back({3{d}});
    end
    chk_model("sb");
  endtask

  task automatic fill_full(input logic [31:0] a, input logic [31:0] b);
    step(1'b0, 1'b1, a, 1'b0);
    step(1'b0, 1'b1, b, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h1,  1'b1, 2'd1, 32'h1,  16'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'h2,  1'b1, 2'd1, 32'h2,  16'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'h3,  1'b1, 2'd1, 32'h3,  16'd0};
    tbl[3]  = '{1'b0, 1'b1, 32'h4,  1'b1, 2'd1, 32'h4,  16'd0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 32'h4,  16'd0};
    tbl[5]  = '{1'b0, 1'b1, 32'hA,  1'b0, 2'd1, 32'hA,  16'd0};
    tbl[6]  = '{1'b0, 1'b1, 32'hB,  1'b0, 2'd2, 32'hA,  16'd0};
    tbl[7]  = '{1'b0, 1'b1, 32'h77, 1'b0, 2'd2, 32'hA,  16'd0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd1, 32'hB,  16'd0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 32'hB,  16'd0};
    tbl[10] = '{1'b0, 1'b1, 32'hA1, 1'b0, 2'd1, 32'hA1, 16'd0};
    tbl[11] = '{1'b0, 1'b1, 32'hB1, 1'b0, 2'd2, 32'hA1, 16'd0};
    tbl[12] = '{1'b1, 1'b1, 32'hC,  1'b0, 2'd0, 32'h0,  16'd2};
    tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 32'h0,  16'd2};
    tbl[14] = '{1'b0, 1'b1, 32'hD,  1'b0, 2'd1, 32'hD,  16'd2};
    tbl[15] = '{1'b1, 1'b0, 32'h0,  1'b1, 2'd0, 32'h0,  16'd2};
    tbl[16] = '{1'b0, 1'b1, 32'hE,  1'b0, 2'd1, 32'hE,  16'd2};
    tbl[17] = '{1'b1, 1'b0, 32'h0,  1'b0, 2'd0, 32'h0,  16'd3};
    tbl[18] = '{1'b0, 1'b1, 32'h10, 1'b0, 2'd1, 32'h10, 16'd3};
    tbl[19] = '{1'b0, 1'b1, 32'h11, 1'b0, 2'd2, 32'h10, 16'd3};
    tbl[20] = '{1'b1, 1'b1, 32'h12, 1'b1, 2'd0, 32'h0,  16'd4};
    tbl[21] = '{1'b1, 1'b1, 32'h13, 1'b1, 2'd0, 32'h0,  16'd4};
    tbl[22] = '{1'b0, 1'b1, 32'h14, 1'b1, 2'd1, 32'h14, 16'd4};
    tbl[23] = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 32'h14, 16'd4};

    i_rst = 1'b1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data = '0;
    #12;
    chk("rst.valid", DW'(o_valid), DW'(0));
    chk("rst.ready", DW'(o_ready), DW'(1));
    chk("rst.count", DW'(o_count), DW'(0));
    chk("rst.drop",  DW'(o_drop_cnt), DW'(0));
    chk("rst.data",  o_data, '0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d.count", i), DW'(o_count), DW'(tbl[i].cnt));
      chk($sformatf("vec%0d.valid", i), DW'(o_valid), DW'(tbl[i].cnt != 2'd0));
      chk($sformatf("vec%0d.ready", i), DW'(o_ready), DW'(tbl[i].cnt != 2'd2));
      chk($sformatf("vec%0d.data", i),  o_data, {3{tbl[i].dat}});
      chk($sformatf("vec%0d.drop", i),  DW'(o_drop_cnt), DW'(tbl[i].drop));
    end

    // Jump the drop counter close to the top, then walk it into saturation with FULL flushes.
    @(negedge i_clk);
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    force dut.drop_q = 16'hFFFA;
    @(posedge i_clk);
    @(negedge i_clk);
    release dut.drop_q;
    m_drop = 16'hFFFA;
    #1;
    chk("sat.preload", DW'(o_drop_cnt), DW'(16'hFFFA));
    fill_full(32'h21, 32'h22);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("sat.fffc", DW'(o_drop_cnt), DW'(16'hFFFC));
    fill_full(32'h23, 32'h24);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("sat.fffe", DW'(o_drop_cnt), DW'(16'hFFFE));
    fill_full(32'h25, 32'h26);
    step(1'b1, 1'b1, 32'h27, 1'b0);
    chk("sat.ffff", DW'(o_drop_cnt), DW'(16'hFFFF));
    fill_full(32'h28, 32'h29);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("sat.hold", DW'(o_drop_cnt), DW'(16'hFFFF));
    step(1'b0, 1'b1, 32'h2A, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("sat.hold1", DW'(o_drop_cnt), DW'(16'hFFFF));

    // Asynchronous reset between edges while FULL.
    fill_full(32'h31, 32'h32);
    chk("ar.pre_count", DW'(o_count), DW'(2));
    #2;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    i_rst = 1'b1;
    #1;
    exp_q.delete();
    m_drop = 0;
    chk("ar.valid", DW'(o_valid), DW'(0));
    chk("ar.ready", DW'(o_ready), DW'(1));
    chk("ar.count", DW'(o_count), DW'(0));
    chk("ar.drop",  DW'(o_drop_cnt), DW'(0));
    chk("ar.data",  o_data, '0);

    // First rising edge after release must already accept a word.
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_valid = 1'b1;
    i_data  = {3{32'h55}};
    @(posedge i_clk);
    #1;
    exp_q.push_back({3{32'h55}});
    chk("ar.first_data", o_data, {3{32'h55}});
    chk_model("ar.first");
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("ar.drain_count", DW'(o_count), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
